// File: rtl/mem_bus_arbiter.sv
// Two-requester (I-cache / D-cache) front end for the shared memory bus, with load-tag ownership tracking.
// Conflicts go to the D-cache by fixed priority; define MEM_ARB_RR_EN for round-robin arbitration instead.
module mem_bus_arbiter #(
    parameter int TAG_NUM = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ic_cmd_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic [3:0]        ic_rsp_o,
    output logic [DATA_W-1:0] ic_data_o,
    output logic [3:0]        ic_tag_o,
    input  logic [1:0]        dc_cmd_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic [3:0]        dc_rsp_o,
    output logic [DATA_W-1:0] dc_data_o,
    output logic [3:0]        dc_tag_o,
    input  logic [3:0]        mem2proc_response_i,
    input  logic [DATA_W-1:0] mem2proc_data_i,
    input  logic [3:0]        mem2proc_tag_i,
    output logic [1:0]        proc2mem_command_o,
    output logic [ADDR_W-1:0] proc2mem_addr_o,
    output logic [DATA_W-1:0] proc2mem_data_o,
    output logic [4:0]        outstanding_cnt_o,
    output logic              arb_error_o
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_cmd_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_e;

    logic [TAG_NUM-1:0] valid_q;
    owner_e             owner_q [TAG_NUM];
    logic [4:0]         cnt_q;
    logic               err_q;

    logic ic_req, dc_req;
    logic grant_ic, grant_dc;
    logic accepted, alloc, alloc_inc, grant_clash;
    logic ret_hit, ret_miss;
    owner_e winner;

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q;
`endif

    // An I-cache store is illegal and is dropped here rather than forwarded.
    always_comb begin
        ic_req = (ic_cmd_i == BUS_LOAD);
        dc_req = (dc_cmd_i == BUS_LOAD) || (dc_cmd_i == BUS_STORE);
`ifdef MEM_ARB_RR_EN
        if (ic_req && dc_req) begin
            grant_dc = (last_grant_q == OWNER_IC);
        end else begin
            grant_dc = dc_req;
        end
`else
        grant_dc = dc_req;
`endif
        grant_ic = ic_req && !grant_dc;
        winner   = grant_dc ? OWNER_DC : OWNER_IC;
    end

    // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        proc2mem_command_o = BUS_NONE;
        proc2mem_addr_o    = '0;
        proc2mem_data_o    = '0;
        ic_rsp_o           = '0;
        dc_rsp_o           = '0;
        if (grant_dc) begin
            proc2mem_command_o = dc_cmd_i;
            proc2mem_addr_o    = dc_addr_i;
            proc2mem_data_o    = dc_data_i;
            dc_rsp_o           = mem2proc_response_i;
        end else if (grant_ic) begin
            proc2mem_command_o = BUS_LOAD;
            proc2mem_addr_o    = ic_addr_i;
            ic_rsp_o           = mem2proc_response_i;
        end
    end

    always_comb begin
        accepted    = (grant_ic || grant_dc) && (mem2proc_response_i != 4'd0);
        alloc       = accepted && (proc2mem_command_o == BUS_LOAD);
        ret_hit     = (mem2proc_tag_i != 4'd0) && valid_q[mem2proc_tag_i];
        ret_miss    = (mem2proc_tag_i != 4'd0) && !valid_q[mem2proc_tag_i];
        // A tag freed by this cycle's return may legally be handed out again at once.
        grant_clash = accepted && valid_q[mem2proc_response_i] &&
                      !(ret_hit && (mem2proc_tag_i == mem2proc_response_i));
        alloc_inc   = alloc && (!valid_q[mem2proc_response_i] ||
                                (ret_hit && (mem2proc_tag_i == mem2proc_response_i)));
    end

    always_comb begin
        ic_tag_o  = '0;
        ic_data_o = '0;
        dc_tag_o  = '0;
        dc_data_o = '0;
        if (ret_hit) begin
            if (owner_q[mem2proc_tag_i] == OWNER_DC) begin
                dc_tag_o  = mem2proc_tag_i;
                dc_data_o = mem2proc_data_i;
            end else begin
                ic_tag_o  = mem2proc_tag_i;
                ic_data_o = mem2proc_data_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (ret_hit) begin
                valid_q[mem2proc_tag_i] <= 1'b0;
            end
            // Later assignment wins, so a same-cycle re-grant keeps the entry valid.
            if (alloc) begin
                valid_q[mem2proc_response_i] <= 1'b1;
            end
            cnt_q <= cnt_q + 5'(alloc_inc) - 5'(ret_hit);
            if (ret_miss || grant_clash || (ic_cmd_i == BUS_STORE)) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: owner bits are meaningless while valid is clear, so this storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            owner_q[mem2proc_response_i] <= winner;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWNER_IC;
        end else if (accepted) begin
            last_grant_q <= winner;
        end
    end
`endif

    assign outstanding_cnt_o = cnt_q;
    assign arb_error_o       = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant, acceptance, tag return, counter, error and reset behaviour.
// Expectations adapt to MEM_ARB_RR_EN where conflict resolution differs.
module tb_mem_bus_arbiter;

    localparam logic [1:0] NONE  = 2'h0;
    localparam logic [1:0] LOAD  = 2'h1;
    localparam logic [1:0] STORE = 2'h2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ic_cmd, dc_cmd;
    logic [63:0] ic_addr, dc_addr, dc_wdata;
    logic [3:0]  ic_rsp, dc_rsp, ic_tag, dc_tag;
    logic [63:0] ic_data, dc_data;
    logic [3:0]  mem_rsp, mem_tag;
    logic [63:0] mem_data;
    logic [1:0]  bus_cmd;
    logic [63:0] bus_addr, bus_data;
    logic [4:0]  cnt;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .ic_cmd_i            (ic_cmd),
        .ic_addr_i           (ic_addr),
        .ic_rsp_o            (ic_rsp),
        .ic_data_o           (ic_data),
        .ic_tag_o            (ic_tag),
        .dc_cmd_i            (dc_cmd),
        .dc_addr_i           (dc_addr),
        .dc_data_i           (dc_wdata),
        .dc_rsp_o            (dc_rsp),
        .dc_data_o           (dc_data),
        .dc_tag_o            (dc_tag),
        .mem2proc_response_i (mem_rsp),
        .mem2proc_data_i     (mem_data),
        .mem2proc_tag_i      (mem_tag),
        .proc2mem_command_o  (bus_cmd),
        .proc2mem_addr_o     (bus_addr),
        .proc2mem_data_o     (bus_data),
        .outstanding_cnt_o   (cnt),
        .arb_error_o         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ic_cmd  = NONE;
        dc_cmd  = NONE;
        mem_rsp = 4'd0;
        mem_tag = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_data = '0;
        idle();
        tick();
        tick();
        check("reset_cnt", 64'(cnt), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_cmd", 64'(bus_cmd), 64'(NONE));
        check("idle_addr", bus_addr, 64'd0);

        // I-cache load alone, tag 3, returned later with 0xDEAD
        ic_cmd = LOAD; ic_addr = 64'h100; mem_rsp = 4'd3;
        #1;
        check("t1_cmd", 64'(bus_cmd), 64'(LOAD));
        check("t1_addr", bus_addr, 64'h100);
        check("t1_data", bus_data, 64'd0);
        check("t1_ic_rsp", 64'(ic_rsp), 64'd3);
        check("t1_dc_rsp", 64'(dc_rsp), 64'd0);
        tick();
        check("t1_cnt1", 64'(cnt), 64'd1);
        idle();
        mem_tag = 4'd3; mem_data = 64'hDEAD;
        #1;
        check("t1_ic_tag", 64'(ic_tag), 64'd3);
        check("t1_ic_data", ic_data, 64'hDEAD);
        check("t1_dc_tag", 64'(dc_tag), 64'd0);
        check("t1_dc_data", dc_data, 64'd0);
        tick();
        check("t1_cnt0", 64'(cnt), 64'd0);
        check("t1_err", 64'(err), 64'd0);

        // Conflict: D-cache wins first, I-cache granted next cycle
        idle();
        dc_cmd = LOAD; dc_addr = 64'h200; ic_cmd = LOAD; ic_addr = 64'h300; mem_rsp = 4'd5;
        #1;
        check("t2_addr", bus_addr, 64'h200);
        check("t2_dc_rsp", 64'(dc_rsp), 64'd5);
        check("t2_ic_rsp", 64'(ic_rsp), 64'd0);
        tick();
        dc_cmd = NONE; mem_rsp = 4'd6;
        #1;
        check("t2_next_addr", bus_addr, 64'h300);
        check("t2_next_ic_rsp", 64'(ic_rsp), 64'd6);
        tick();
        check("t2_cnt", 64'(cnt), 64'd2);

        // Two back-to-back conflicts: the second one exposes the policy
        dc_cmd = LOAD; dc_addr = 64'h400; ic_cmd = LOAD; ic_addr = 64'h500; mem_rsp = 4'd8;
        #1;
        check("t2b_dc_rsp", 64'(dc_rsp), 64'd8);
        check("t2b_ic_rsp", 64'(ic_rsp), 64'd0);
        tick();
        mem_rsp = 4'd9;
        #1;
`ifdef MEM_ARB_RR_EN
        check("t2c_addr", bus_addr, 64'h500);
        check("t2c_ic_rsp", 64'(ic_rsp), 64'd9);
        check("t2c_dc_rsp", 64'(dc_rsp), 64'd0);
`else
        check("t2c_addr", bus_addr, 64'h400);
        check("t2c_dc_rsp", 64'(dc_rsp), 64'd9);
        check("t2c_ic_rsp", 64'(ic_rsp), 64'd0);
`endif
        tick();
        check("t2c_cnt", 64'(cnt), 64'd4);
        idle();
        mem_tag = 4'd5; mem_data = 64'h55;
        #1;
        check("t2_ret5_dc", 64'(dc_tag), 64'd5);
        check("t2_ret5_ic", 64'(ic_tag), 64'd0);
        tick();
        mem_tag = 4'd6; mem_data = 64'h66;
        #1;
        check("t2_ret6_ic", 64'(ic_tag), 64'd6);
        check("t2_ret6_data", ic_data, 64'h66);
        tick();
        mem_tag = 4'd8;
        #1;
        check("t2_ret8_dc", 64'(dc_tag), 64'd8);
        tick();
        mem_tag = 4'd9;
        #1;
`ifdef MEM_ARB_RR_EN
        check("t2_ret9_ic", 64'(ic_tag), 64'd9);
`else
        check("t2_ret9_dc", 64'(dc_tag), 64'd9);
`endif
        tick();
        check("t2_drain_cnt", 64'(cnt), 64'd0);
        check("t2_err", 64'(err), 64'd0);

        // D-cache store allocates nothing; its tag returning later is an error
        idle();
        dc_cmd = STORE; dc_addr = 64'h40; dc_wdata = 64'h1234; mem_rsp = 4'd2;
        #1;
        check("t3_cmd", 64'(bus_cmd), 64'(STORE));
        check("t3_data", bus_data, 64'h1234);
        check("t3_dc_rsp", 64'(dc_rsp), 64'd2);
        tick();
        check("t3_cnt", 64'(cnt), 64'd0);
        check("t3_err0", 64'(err), 64'd0);
        idle();
        mem_tag = 4'd2; mem_data = 64'h77;
        #1;
        check("t3_no_fwd_dc", 64'(dc_tag), 64'd0);
        check("t3_no_fwd_ic", 64'(ic_tag), 64'd0);
        tick();
        check("t3_err1", 64'(err), 64'd1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_err_cleared", 64'(err), 64'd0);

        // Memory busy for three cycles, then accepts with tag 7
        ic_cmd = LOAD; ic_addr = 64'h700; mem_rsp = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_busy_rsp", 64'(ic_rsp), 64'd0);
            check("t4_busy_cmd", 64'(bus_cmd), 64'(LOAD));
            tick();
            check("t4_busy_cnt", 64'(cnt), 64'd0);
        end
        mem_rsp = 4'd7;
        #1;
        check("t4_rsp", 64'(ic_rsp), 64'd7);
        tick();
        check("t4_cnt", 64'(cnt), 64'd1);

        // Tag 4 returns to the I-cache while being re-granted to the D-cache
        mem_rsp = 4'd4;
        tick();
        check("t5_cnt_pre", 64'(cnt), 64'd2);
        idle();
        mem_tag = 4'd4; mem_data = 64'hAB;
        dc_cmd = LOAD; dc_addr = 64'h800; mem_rsp = 4'd4;
        #1;
        check("t5_ic_tag", 64'(ic_tag), 64'd4);
        check("t5_ic_data", ic_data, 64'hAB);
        check("t5_dc_tag", 64'(dc_tag), 64'd0);
        check("t5_dc_rsp", 64'(dc_rsp), 64'd4);
        tick();
        check("t5_cnt", 64'(cnt), 64'd2);
        check("t5_err", 64'(err), 64'd0);
        idle();
        mem_tag = 4'd4; mem_data = 64'hCD;
        #1;
        check("t5_new_owner", 64'(dc_tag), 64'd4);
        check("t5_new_owner_ic", 64'(ic_tag), 64'd0);
        tick();
        check("t5_cnt_after", 64'(cnt), 64'd1);

        // I-cache store is dropped and flagged
        idle();
        ic_cmd = STORE; ic_addr = 64'h900;
        #1;
        check("t6_ic_store_cmd", 64'(bus_cmd), 64'(NONE));
        tick();
        check("t6_ic_store_err", 64'(err), 64'd1);

        // Reset with three tags outstanding (7, 10, 11)
        idle();
        ic_cmd = LOAD; ic_addr = 64'hA00; mem_rsp = 4'd10;
        tick();
        mem_rsp = 4'd11;
        tick();
        check("t7_cnt3", 64'(cnt), 64'd3);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_cnt_rst", 64'(cnt), 64'd0);
        check("t7_err_rst", 64'(err), 64'd0);
        mem_tag = 4'd10; mem_data = 64'hEE;
        #1;
        check("t7_stale_ic", 64'(ic_tag), 64'd0);
        tick();
        check("t7_stale_err", 64'(err), 64'd1);
        check("t7_stale_cnt", 64'(cnt), 64'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
